// File: rtl/addsub_seg_mux.sv
// rtl/addsub_seg_mux.sv - signed add/subtract with double-dabble BCD and 7-segment scan
//
// Captures two signed operands on START and forms A+B or A-B at WIDTH+1 bits.
// The magnitude is converted to BCD one bit per cycle and latched into the
// display registers, which a free-running refresh counter scans onto the
// common-anode digits. The top digit is the sign; the rest are magnitude.
//
// Optional build macro: LZB_EN - blank leading-zero magnitude digits.
//
// Ports:
//   CLK    in   system clock
//   RSTn   in   asynchronous active-low reset
//   A, B   in   WIDTH-bit two's-complement operands
//   SUB    in   0 = A+B, 1 = A-B
//   START  in   conversion request, sampled every rising edge while idle
//   BUSY   out  conversion in progress
//   DONE   out  one-cycle pulse when the display registers update
//   OVF    out  latched: magnitude does not fit in DIGITS-1 decimal digits
//   SEG    out  active-low segments, SEG[6]=a .. SEG[0]=g
//   AN     out  active-low digit enables, AN[0] = units
module addsub_seg_mux #(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic              SUB,
  input  logic              START,
  output logic              BUSY,
  output logic              DONE,
  output logic              OVF,
  output logic [6:0]        SEG,
  output logic [DIGITS-1:0] AN
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Decimal digit count of 2**w: the BCD register must hold the largest magnitude.
  function automatic int dec_digits(input int w);
    longint unsigned v;
    int n;
    v = 64'd1 << w;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (v != 0) begin
        v = v / 10;
        n++;
      end
    end
    return n;
  endfunction

  function automatic longint unsigned dec_limit(input int d);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p - 1;
  endfunction

  localparam int MW     = WIDTH + 1;
  localparam int NB_MAG = dec_digits(WIDTH);
  localparam int NB     = (NB_MAG > DIGITS - 1) ? NB_MAG : DIGITS - 1;
  localparam int BW     = 4 * NB;
  localparam int DW     = 4 * (DIGITS - 1);
  localparam int CW     = $clog2(WIDTH + 2);
  localparam int RW     = $clog2(REFRESH_DIV);
  localparam int IW     = $clog2(DIGITS);
  localparam logic [31:0] LIMIT = 32'(dec_limit(DIGITS - 1));

  logic [1:0]       state;
  logic [WIDTH-1:0] op_a, op_b;
  logic             op_sub;
  logic [MW-1:0]    mag;
  logic             sign_r, ovf_n;
  logic [BW-1:0]    bcd;
  logic [CW-1:0]    cnt;
  logic             busy_q, done_q, ovf_q, disp_sign;
  logic [DW-1:0]    disp_bcd;

  logic [MW-1:0]    r_calc, mag_calc;
  logic             ovf_calc;
  logic [BW-1:0]    bcd_adj, bcd_next;
  logic             unused_bcd_top;

  always_comb begin
    if (op_sub) r_calc = {op_a[WIDTH-1], op_a} - {op_b[WIDTH-1], op_b};
    else        r_calc = {op_a[WIDTH-1], op_a} + {op_b[WIDTH-1], op_b};
    // Negating -2**WIDTH wraps to the same bit pattern, read as unsigned 2**WIDTH.
    mag_calc = r_calc[WIDTH] ? (~r_calc + 1'b1) : r_calc;
    ovf_calc = 32'(mag_calc) > LIMIT;
    bcd_adj = '0;
    for (int i = 0; i < NB; i++) begin
      bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
    bcd_next = {bcd_adj[BW-2:0], mag[MW-1]};
  end

  // The top BCD bit can never be set after adjustment, so it is shifted out.
  assign unused_bcd_top = bcd_adj[BW-1];

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= S_IDLE;
      op_a      <= '0;
      op_b      <= '0;
      op_sub    <= 1'b0;
      mag       <= '0;
      sign_r    <= 1'b0;
      ovf_n     <= 1'b0;
      bcd       <= '0;
      cnt       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      disp_sign <= 1'b0;
      disp_bcd  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            op_a   <= A;
            op_b   <= B;
            op_sub <= SUB;
            busy_q <= 1'b1;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          mag    <= mag_calc;
          sign_r <= r_calc[WIDTH];
          ovf_n  <= ovf_calc;
          bcd    <= '0;
          cnt    <= '0;
          state  <= S_SHIFT;
        end
        S_SHIFT: begin
          bcd <= bcd_next;
          mag <= mag << 1;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH)) state <= S_DONE;
        end
        default: begin
          disp_sign <= sign_r;
          disp_bcd  <= bcd[DW-1:0];
          ovf_q     <= ovf_n;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b0000001;
      4'd1:    seg_decode = 7'b1001111;
      4'd2:    seg_decode = 7'b0010010;
      4'd3:    seg_decode = 7'b0000110;
      4'd4:    seg_decode = 7'b1001100;
      4'd5:    seg_decode = 7'b0100100;
      4'd6:    seg_decode = 7'b0100000;
      4'd7:    seg_decode = 7'b0001111;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0000100;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  logic [RW-1:0]     ref_cnt;
  logic [IW-1:0]     idx, idx_new;
  logic              scan_on;
  logic [DIGITS-1:0] an_q;
  logic [6:0]        seg_q, seg_new;
  logic [3:0]        nib;

`ifdef LZB_EN
  // lz[i] set when nibbles i..DIGITS-2 are all zero.
  logic [DIGITS-2:0] lz;
  logic              lz_acc;
  always_comb begin
    lz     = '0;
    lz_acc = 1'b1;
    for (int i = DIGITS - 2; i >= 0; i--) begin
      lz_acc = lz_acc & (disp_bcd[4*i +: 4] == 4'd0);
      lz[i]  = lz_acc;
    end
  end
`endif

  always_comb begin
    // scan_on makes the first terminal count after reset land on digit 0.
    if (!scan_on || idx == IW'(DIGITS - 1)) idx_new = '0;
    else                                    idx_new = idx + 1'b1;
  end

  always_comb begin
    seg_new = 7'b1111111;
    nib     = 4'd0;
    if (idx_new == IW'(DIGITS - 1)) begin
      seg_new = disp_sign ? 7'b1111110 : 7'b1111111;
    end else if (ovf_q) begin
      seg_new = 7'b0110000;
    end else begin
      nib     = disp_bcd[4*int'(idx_new) +: 4];
      seg_new = seg_decode(nib);
`ifdef LZB_EN
      if (idx_new != '0 && lz[idx_new]) seg_new = 7'b1111111;
`endif
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ref_cnt <= '0;
      idx     <= '0;
      scan_on <= 1'b0;
      an_q    <= '1;
      seg_q   <= 7'b1111111;
    end else if (ref_cnt == RW'(REFRESH_DIV - 1)) begin
      ref_cnt <= '0;
      idx     <= idx_new;
      scan_on <= 1'b1;
      an_q    <= ~(DIGITS'(1) << idx_new);
      seg_q   <= seg_new;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign OVF  = ovf_q;
  assign SEG  = seg_q;
  assign AN   = an_q;

endmodule

// File: tb/tb_addsub_seg_mux.sv
// tb/tb_addsub_seg_mux.sv - directed bench for addsub_seg_mux (4-digit and 3-digit builds)
module tb_addsub_seg_mux;

  logic       CLK, RSTn, SUB, START;
  logic [7:0] A, B;
  logic       BUSY4, DONE4, OVF4;
  logic [6:0] SEG4;
  logic [3:0] AN4;
  logic       BUSY3, DONE3, OVF3;
  logic [6:0] SEG3;
  logic [2:0] AN3;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] BL = 7'h7F;
  localparam logic [6:0] MI = 7'h7E;
  localparam logic [6:0] EE = 7'h30;
  localparam logic [6:0] S0 = 7'h01;
  localparam logic [6:0] S1 = 7'h4F;
  localparam logic [6:0] S2 = 7'h12;
  localparam logic [6:0] S5 = 7'h24;
  localparam logic [6:0] S6 = 7'h20;
  localparam logic [6:0] S7 = 7'h0F;
`ifdef LZB_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h01;
`endif

  addsub_seg_mux #(.WIDTH(8), .DIGITS(4), .REFRESH_DIV(4)) u_dut4 (
    .CLK(CLK), .RSTn(RSTn), .A(A), .B(B), .SUB(SUB), .START(START),
    .BUSY(BUSY4), .DONE(DONE4), .OVF(OVF4), .SEG(SEG4), .AN(AN4)
  );

  addsub_seg_mux #(.WIDTH(8), .DIGITS(3), .REFRESH_DIV(4)) u_dut3 (
    .CLK(CLK), .RSTn(RSTn), .A(A), .B(B), .SUB(SUB), .START(START),
    .BUSY(BUSY3), .DONE(DONE3), .OVF(OVF3), .SEG(SEG3), .AN(AN3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic read_digit(input int dut, input int i, output logic [6:0] s);
    logic [3:0] want, an_now;
    bit found;
    want  = ~(4'b0001 << i);
    found = 0;
    s     = 7'h00;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge CLK);
      an_now = (dut == 4) ? AN4 : {1'b1, AN3};
      if (an_now == want) begin
        found = 1;
        s = (dut == 4) ? SEG4 : SEG3;
      end
    end
    check($sformatf("scan_found_dut%0d_d%0d", dut, i), 32'(found), 32'd1);
  endtask

  task automatic disp(input int dut, input string tag,
                      input logic [6:0] d3, input logic [6:0] d2,
                      input logic [6:0] d1, input logic [6:0] d0);
    logic [6:0] s;
    repeat (20) @(negedge CLK);
    read_digit(dut, 0, s); check({tag, "_d0"}, 32'(s), 32'(d0));
    read_digit(dut, 1, s); check({tag, "_d1"}, 32'(s), 32'(d1));
    read_digit(dut, 2, s); check({tag, "_d2"}, 32'(s), 32'(d2));
    if (dut == 4) begin
      read_digit(dut, 3, s); check({tag, "_d3"}, 32'(s), 32'(d3));
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic sub);
    int nb;
    bit got;
    @(negedge CLK);
    A = a; B = b; SUB = sub; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    nb = 0;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (DONE4) got = 1;
      else begin
        if (BUSY4) nb++;
        @(negedge CLK);
      end
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_busy_cycles"}, 32'(nb), 32'd11);
    check({tag, "_busy_at_done"}, 32'(BUSY4), 32'd0);
    check({tag, "_done3"}, 32'(DONE3), 32'd1);
    @(negedge CLK);
    check({tag, "_done_pulse"}, 32'(DONE4), 32'd0);
  endtask

  task automatic an_step(input string tag, input logic [3:0] from, input logic [3:0] to);
    int n;
    for (int k = 0; k < 40 && AN4 == from; k++) @(negedge CLK);
    for (int k = 0; k < 40 && AN4 != from; k++) @(negedge CLK);
    n = 0;
    for (int k = 0; k < 40 && AN4 == from; k++) begin
      @(negedge CLK);
      n++;
    end
    check({tag, "_slot_len"}, 32'(n), 32'd4);
    check({tag, "_next_an"}, 32'(AN4), 32'(to));
  endtask

  initial begin
    int n, t, nd, d1, d2;
    RSTn = 1'b0; START = 1'b0; A = '0; B = '0; SUB = 1'b0;

    repeat (3) @(negedge CLK);
    check("rst_seg", 32'(SEG4), 32'h7F);
    check("rst_an", 32'(AN4), 32'hF);
    check("rst_an3", 32'(AN3), 32'h7);
    check("rst_busy", 32'(BUSY4), 32'd0);
    check("rst_done", 32'(DONE4), 32'd0);
    check("rst_ovf", 32'(OVF4), 32'd0);

    RSTn = 1'b1;
    n = 0;
    for (int k = 0; k < 10 && AN4 == 4'hF; k++) begin
      @(negedge CLK);
      n++;
    end
    check("first_tick_delay", 32'(n), 32'd4);
    check("first_tick_an", 32'(AN4), 32'hE);
    check("first_tick_seg", 32'(SEG4), 32'(S0));
    check("first_tick_an3", 32'(AN3), 32'h6);

    repeat (6) @(negedge CLK);
    RSTn = 1'b0;
    #1;
    check("midscan_rst_seg", 32'(SEG4), 32'h7F);
    check("midscan_rst_an", 32'(AN4), 32'hF);
    check("midscan_rst_an3", 32'(AN3), 32'h7);
    check("midscan_rst_busy", 32'(BUSY4), 32'd0);
    @(negedge CLK);
    RSTn = 1'b1;

    run_op("add", 8'd100, 8'd27, 1'b0);
    check("add_ovf4", 32'(OVF4), 32'd0);
    check("add_ovf3", 32'(OVF3), 32'd1);
    disp(4, "add4", BL, S1, S2, S7);
    disp(3, "add3", 7'h00, BL, EE, EE);
    an_step("scan0", 4'hE, 4'hD);
    an_step("scanwrap", 4'h7, 4'hE);

    run_op("neg255", 8'h80, 8'd127, 1'b1);
    check("neg255_ovf4", 32'(OVF4), 32'd0);
    check("neg255_ovf3", 32'(OVF3), 32'd1);
    disp(4, "neg255_4", MI, S2, S5, S5);
    disp(3, "neg255_3", 7'h00, MI, EE, EE);

    run_op("neg256", 8'h80, 8'h80, 1'b0);
    check("neg256_ovf4", 32'(OVF4), 32'd0);
    disp(4, "neg256_4", MI, S2, S5, S6);

    run_op("p100", 8'd50, 8'd50, 1'b0);
    check("p100_ovf3", 32'(OVF3), 32'd1);
    check("p100_ovf4", 32'(OVF4), 32'd0);
    disp(3, "p100_3", 7'h00, BL, EE, EE);
    disp(4, "p100_4", BL, S1, S0, S0);

    run_op("p1", 8'hCF, 8'd50, 1'b0);
    check("p1_ovf3", 32'(OVF3), 32'd0);
    disp(3, "p1_3", 7'h00, BL, LZ, S1);
    disp(4, "p1_4", BL, LZ, LZ, S1);

    @(negedge CLK);
    A = 8'd10; B = 8'd5; SUB = 1'b0; START = 1'b1;
    @(negedge CLK); t = 1;
    @(negedge CLK); t = 2; A = 8'd120;
    nd = 0; d1 = 0; d2 = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      t++;
      if (DONE4) begin
        nd++;
        if (nd == 1) begin
          d1 = t;
          check("hs_first_ovf3", 32'(OVF3), 32'd0);
        end else if (nd == 2) begin
          d2 = t;
          check("hs_second_ovf3", 32'(OVF3), 32'd1);
        end
      end
      if (nd == 1 && t == d1 + 1) START = 1'b0;
    end
    check("hs_done_count", 32'(nd), 32'd2);
    check("hs_first_latency", 32'(d1), 32'd12);
    check("hs_period", 32'(d2 - d1), 32'd12);
    disp(4, "hs4", BL, S1, S2, S5);

    @(negedge CLK);
    A = 8'd3; B = 8'd4; SUB = 1'b0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (4) @(negedge CLK);
    check("shift_busy_before_rst", 32'(BUSY4), 32'd1);
    RSTn = 1'b0;
    #1;
    check("shift_rst_busy", 32'(BUSY4), 32'd0);
    check("shift_rst_an", 32'(AN4), 32'hF);
    check("shift_rst_seg", 32'(SEG4), 32'h7F);
    @(negedge CLK);
    RSTn = 1'b1;
    nd = 0;
    repeat (20) begin
      @(negedge CLK);
      if (DONE4) nd++;
    end
    check("shift_rst_no_done", 32'(nd), 32'd0);
    check("shift_rst_ovf3", 32'(OVF3), 32'd0);
    disp(4, "shift_rst_disp", BL, LZ, LZ, S0);

    run_op("after_rst", 8'd3, 8'd4, 1'b0);
    disp(4, "after_rst4", BL, LZ, LZ, S7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
